// File: rtl/chacha20_pkg.sv
// Shared constants and state encodings for the ChaCha20 keystream streamer.
package chacha20_pkg;
   localparam int BLOCK_BYTES = 64;
   localparam int BLOCK_BITS  = 512;

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_st_t;
   typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND, T_NEXT} tx_st_t;

   function automatic int baud_div(int clk_hz, int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction
endpackage

// File: rtl/chacha20_uart_streamer_if.sv
// Request/response bundle between the streamer and the keystream core.
interface chacha20_uart_streamer_if;
   logic                              ks_start;
   logic [31:0]                       ks_counter;
   logic                              ks_done;
   logic [chacha20_pkg::BLOCK_BITS-1:0] ks_data;

   modport master (output ks_start, ks_counter, input ks_done, ks_data);
   modport slave  (input ks_start, ks_counter, output ks_done, ks_data);
endinterface

// File: rtl/chacha20_uart_streamer_uart_byte_tx.sv
// Single-byte UART transmitter, back-to-back capable.
// UART_PARITY_EN adds an even-parity bit after data bit 7.
module uart_byte_tx
   import chacha20_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);
   localparam int DIV = baud_div(CLK_HZ, BAUD);
   localparam int CW  = $clog2(DIV + 1);
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic             active;
   logic [NBITS-1:0] frame;
   logic [NBITS-1:0] load;
   logic [CW-1:0]    baud_cnt;
   logic [3:0]       bit_cnt;
   logic             bit_end;
   logic             last;

`ifdef UART_PARITY_EN
   assign load = {1'b1, ^data, data, 1'b0};
`else
   assign load = {1'b1, data, 1'b0};
`endif

   assign bit_end = baud_cnt == CW'(DIV - 1);
   assign last    = active && bit_end && bit_cnt == 4'(NBITS - 1);
   // Accepting during the last stop-bit clock keeps frames gapless
   assign ready   = !active || last;
   assign tx      = active ? frame[0] : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active   <= 1'b0;
         frame    <= '1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (valid && ready) begin
         active   <= 1'b1;
         frame    <= load;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            frame    <= {1'b1, frame[NBITS-1:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (last) active <= 1'b0;
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/chacha20_uart_streamer.sv
// Multi-block ChaCha20 keystream fetcher with gapless UART output.
// UART_PARITY_EN selects 8E1 framing in uart_byte_tx.
module chacha20_uart_streamer
   import chacha20_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int NBLK_W    = 16,
   parameter int MSB_FIRST = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [31:0]            base_counter,
   input  logic [NBLK_W-1:0]      block_count,
   input  logic                   abort,
   chacha20_uart_streamer_if.master ks,
   output logic                   uart_tx,
   output logic                   busy,
   output logic                   done,
   output logic [NBLK_W-1:0]      blocks_sent,
   output logic                   led_done
);
   fetch_st_t f_st, f_nx;
   tx_st_t    t_st, t_nx;

   logic [BLOCK_BITS-1:0] hold, shift;
   logic                  hold_full;
   logic [5:0]            byte_idx;
   logic [31:0]           req_ctr;
   logic [NBLK_W-1:0]     reqs_left, nblk;
   logic                  aborting, line_busy, pend;

   logic       start_acc, abort_acc, halt, fetch_ok, latch;
   logic       fin_blk, last_blk, abort_end;
   logic       u_valid, u_ready, u_acc;
   logic [7:0] u_data;

   assign start_acc = start && !busy;
   // pend marks byte 63 on the line; the next ready is its stop-bit end
   assign fin_blk   = pend && u_ready;
   assign last_blk  = fin_blk && (blocks_sent + NBLK_W'(1) == nblk);
   assign abort_acc = abort && busy && !aborting && !last_blk;
   assign halt      = aborting || abort_acc;
   assign fetch_ok  = busy && !halt && reqs_left != '0 && !hold_full;
   assign latch     = f_st == F_WAIT && ks.ks_done && !halt;
   assign abort_end = aborting && !line_busy && f_st == F_IDLE;

   assign u_valid = t_st == T_SEND && !halt;
   assign u_acc   = u_valid && u_ready;
   assign u_data  = (MSB_FIRST != 0) ? shift[BLOCK_BITS-1 -: 8] : shift[7:0];
   assign ks.ks_counter = req_ctr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_st <= F_IDLE;
         t_st <= T_IDLE;
      end else begin
         f_st <= f_nx;
         t_st <= t_nx;
      end
   end

   always_comb begin
      f_nx        = f_st;
      ks.ks_start = 1'b0;
      unique case (f_st)
         F_IDLE: if ((start_acc && block_count != '0) || fetch_ok) f_nx = F_REQ;
         F_REQ: begin
            ks.ks_start = 1'b1;
            f_nx        = F_WAIT;
         end
         F_WAIT: if (ks.ks_done) f_nx = F_IDLE;
         default: f_nx = F_IDLE;
      endcase
   end

   always_comb begin
      t_nx = t_st;
      unique case (t_st)
         T_IDLE: if (hold_full && !halt) t_nx = T_LOAD;
         T_LOAD: t_nx = T_SEND;
         T_SEND: if (u_acc && byte_idx == 6'(BLOCK_BYTES - 1)) t_nx = T_NEXT;
         T_NEXT: begin
            if (hold_full && !halt) t_nx = T_LOAD;
            else if (!pend)         t_nx = T_IDLE;
         end
         default: t_nx = T_IDLE;
      endcase
      if (abort_end) t_nx = T_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold        <= '0;
         hold_full   <= 1'b0;
         shift       <= '0;
         byte_idx    <= '0;
         req_ctr     <= '0;
         reqs_left   <= '0;
         nblk        <= '0;
         blocks_sent <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         led_done    <= 1'b0;
         aborting    <= 1'b0;
         line_busy   <= 1'b0;
         pend        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start_acc) begin
            req_ctr     <= base_counter;
            reqs_left   <= block_count;
            nblk        <= block_count;
            blocks_sent <= '0;
            busy        <= block_count != '0;
            done        <= block_count == '0;
            led_done    <= block_count == '0;
         end
         if (latch) begin
            hold      <= ks.ks_data;
            hold_full <= 1'b1;
            req_ctr   <= req_ctr + 32'd1;
            reqs_left <= reqs_left - NBLK_W'(1);
         end
         if (t_st == T_LOAD) begin
            shift     <= hold;
            hold_full <= 1'b0;
            byte_idx  <= '0;
         end else if (u_acc) begin
            shift    <= (MSB_FIRST != 0) ? shift << 8 : shift >> 8;
            byte_idx <= byte_idx + 6'd1;
         end
         if (u_acc)        line_busy <= 1'b1;
         else if (u_ready) line_busy <= 1'b0;
         if (u_acc && byte_idx == 6'(BLOCK_BYTES - 1)) pend <= 1'b1;
         else if (fin_blk)                               pend <= 1'b0;
         if (fin_blk) blocks_sent <= blocks_sent + NBLK_W'(1);
         if (last_blk) begin
            done     <= 1'b1;
            led_done <= 1'b1;
            busy     <= 1'b0;
            aborting <= 1'b0;
         end
         if (abort_acc) aborting <= 1'b1;
         if (abort_end) begin
            aborting  <= 1'b0;
            busy      <= 1'b0;
            hold_full <= 1'b0;
            shift     <= '0;
            pend      <= 1'b0;
         end
      end
   end

   uart_byte_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .data  (u_data),
      .valid (u_valid),
      .ready (u_ready),
      .tx    (uart_tx)
   );
endmodule

// File: tb/tb_chacha20_uart_streamer.sv
// Directed bench: behavioural 20-cycle keystream core plus a UART frame monitor.
`timescale 1ns/1ps
module tb_chacha20_uart_streamer;
   localparam int DIV = 10;
`ifdef UART_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FCYC = DIV * FBITS;
   localparam int LAT  = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] base_counter = '0;
   logic [15:0] block_count = '0;
   logic        uart_tx, busy, done, led_done;
   logic [15:0] blocks_sent;

   chacha20_uart_streamer_if ks ();

   chacha20_uart_streamer #(
      .CLK_HZ(1000), .BAUD(100), .NBLK_W(16), .MSB_FIRST(0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_counter (base_counter),
      .block_count  (block_count),
      .abort        (abort),
      .ks           (ks.master),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .done         (done),
      .blocks_sent  (blocks_sent),
      .led_done     (led_done)
   );

   always #5 clk = ~clk;

   // Serialized ChaCha20 block for key 00..1f, nonce 000000090000004a00000000, counter 1
   logic [7:0] tv [64] = '{
      8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
      8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4,
      8'hc7, 8'hd1, 8'hf4, 8'hc7, 8'h33, 8'hc0, 8'h68, 8'h03,
      8'h04, 8'h22, 8'haa, 8'h9a, 8'hc3, 8'hd4, 8'h6c, 8'h4e,
      8'hd2, 8'h82, 8'h64, 8'h46, 8'h07, 8'h9f, 8'haa, 8'h09,
      8'h14, 8'hc2, 8'hd7, 8'h05, 8'hd9, 8'h8b, 8'h02, 8'ha2,
      8'hb5, 8'h12, 8'h9c, 8'hd1, 8'hde, 8'h16, 8'h4e, 8'hb9,
      8'hcb, 8'hd0, 8'h83, 8'he8, 8'ha2, 8'h50, 8'h3c, 8'h4e
   };

   function automatic logic [7:0] kbyte(logic [31:0] c, int k);
      if (c == 32'd1) return tv[k];
      return c[7:0] ^ 8'(k * 37) ^ 8'ha5;
   endfunction

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          lat_cnt;
   logic [31:0] cur_c;
   logic [511:0] d_tmp;
   logic [31:0] ctr_log[$];
   always @(posedge clk) begin
      if (rst) begin
         ks.ks_done <= 1'b0;
         ks.ks_data <= '0;
         lat_cnt    <= 0;
      end else begin
         ks.ks_done <= 1'b0;
         if (ks.ks_start) begin
            cur_c   <= ks.ks_counter;
            lat_cnt <= LAT;
            ctr_log.push_back(ks.ks_counter);
         end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
               for (int k = 0; k < 64; k++) d_tmp[8*k +: 8] = kbyte(cur_c, k);
               ks.ks_done <= 1'b1;
               ks.ks_data <= d_tmp;
            end
         end
      end
   end

   int done_cnt = 0;
   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   logic [7:0]  rx_q[$];
   int unsigned rx_t[$];
   int          stop_err = 0;
   int          par_err = 0;
   initial begin : mon
      logic [7:0]  b;
      int unsigned t0;
      forever begin
         @(negedge clk);
         if (!rst && uart_tx === 1'b0) begin
            t0 = cyc;
            repeat (DIV / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = uart_tx;
            end
`ifdef UART_PARITY_EN
            repeat (DIV) @(negedge clk);
            if (uart_tx !== ^b) par_err++;
`endif
            repeat (DIV) @(negedge clk);
            if (uart_tx !== 1'b1) stop_err++;
            rx_q.push_back(b);
            rx_t.push_back(t0);
            repeat (DIV / 2) @(negedge clk);
         end
      end
   end

   int total = 0;
   int bad = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(logic [31:0] b, logic [15:0] n);
      base_counter = b;
      block_count  = n;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   task automatic wait_idle(string tag, int lim);
      int n = 0;
      while (busy !== 1'b0 && n < lim) begin
         tick();
         n++;
      end
      chk({tag, " idle_in_time"}, n < lim, 1'b1);
   endtask

   task automatic check_run(string tag, int q0, int c0, logic [31:0] base, int nb);
      int cerr = 0;
      int nerr = 0;
      int idx;
      chk({tag, " nreq"}, ctr_log.size() - c0, nb);
      chk({tag, " nframes"}, rx_q.size() - q0, 64 * nb);
      for (int b = 0; b < nb; b++) begin
         if (c0 + b >= ctr_log.size() || ctr_log[c0 + b] !== base + 32'(b)) cerr++;
         for (int k = 0; k < 64; k++) begin
            idx = q0 + 64 * b + k;
            if (idx >= rx_q.size() || rx_q[idx] !== kbyte(base + 32'(b), k)) nerr++;
         end
      end
      chk({tag, " ctr_seq"}, cerr, 0);
      chk({tag, " bytes"}, nerr, 0);
   endtask

   initial begin : main
      int q0, c0, d0, n, gaps;
      int unsigned t_drop;

      tick(3);
      chk("rst uart_tx", uart_tx, 1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst ks_start", ks.ks_start, 1'b0);
      chk("rst ks_counter", ks.ks_counter, 32'h0);
      chk("rst blocks_sent", blocks_sent, 16'h0);
      chk("rst led_done", led_done, 1'b0);
      rst = 1'b0;
      tick(2);

      // 1: single test-vector block
      q0 = rx_q.size(); c0 = ctr_log.size(); d0 = done_cnt;
      pulse_start(32'd1, 16'd1);
      chk("t1 busy", busy, 1'b1);
      wait_idle("t1", 8000);
      tick(20);
      check_run("t1", q0, c0, 32'd1, 1);
      if (rx_q.size() > q0) chk("t1 byte0", rx_q[q0], 8'h10);
      chk("t1 done_cnt", done_cnt - d0, 1);
      chk("t1 blocks_sent", blocks_sent, 16'd1);
      chk("t1 led_done", led_done, 1'b1);

      // 2: counter wrap, three gapless blocks
      q0 = rx_q.size(); c0 = ctr_log.size(); d0 = done_cnt;
      pulse_start(32'hffff_ffff, 16'd3);
      chk("t2 led_cleared", led_done, 1'b0);
      wait_idle("t2", 25000);
      tick(20);
      check_run("t2", q0, c0, 32'hffff_ffff, 3);
      if (ctr_log.size() > c0 + 1) chk("t2 wrap_ctr", ctr_log[c0 + 1], 32'h0);
      gaps = 0;
      for (int i = q0 + 1; i < rx_q.size(); i++)
         if (rx_t[i] - rx_t[i - 1] != FCYC) gaps++;
      chk("t2 gaps", gaps, 0);
      chk("t2 done_cnt", done_cnt - d0, 1);
      chk("t2 blocks_sent", blocks_sent, 16'd3);

      // 3: zero-length run
      q0 = rx_q.size(); c0 = ctr_log.size(); d0 = done_cnt;
      pulse_start(32'd7, 16'd0);
      chk("t3 done_next", done, 1'b1);
      chk("t3 busy", busy, 1'b0);
      tick();
      chk("t3 done_once", done, 1'b0);
      tick(300);
      chk("t3 no_req", ctr_log.size() - c0, 0);
      chk("t3 no_frames", rx_q.size() - q0, 0);
      chk("t3 uart_idle", uart_tx, 1'b1);
      chk("t3 led_done", led_done, 1'b1);

      // 4: start while busy is ignored
      q0 = rx_q.size(); c0 = ctr_log.size(); d0 = done_cnt;
      pulse_start(32'd5, 16'd2);
      tick(1000);
      pulse_start(32'd100, 16'd7);
      wait_idle("t4", 15000);
      tick(20);
      check_run("t4", q0, c0, 32'd5, 2);
      chk("t4 done_cnt", done_cnt - d0, 1);
      chk("t4 blocks_sent", blocks_sent, 16'd2);

      // 5: abort during frame 5 of block 0
      q0 = rx_q.size(); d0 = done_cnt;
      pulse_start(32'd40, 16'd2);
      n = 0;
      while (rx_q.size() < q0 + 5 && n < 2000) begin
         tick();
         n++;
      end
      chk("t5 reach_frame5", n < 2000, 1'b1);
      tick(30);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5 busy_during_frame", busy, 1'b1);
      wait_idle("t5", 300);
      t_drop = cyc;
      tick(3 * FCYC);
      chk("t5 nframes", rx_q.size() - q0, 6);
      if (rx_q.size() > q0 + 5) begin
         chk("t5 frame5_byte", rx_q[q0 + 5], kbyte(32'd40, 5));
         chk("t5 drop_after_stop", t_drop >= rx_t[q0 + 5] + FCYC, 1'b1);
      end
      chk("t5 no_done", done_cnt - d0, 0);
      chk("t5 blocks_sent", blocks_sent, 16'd0);
      chk("t5 stop_bits", stop_err, 0);
      q0 = rx_q.size(); c0 = ctr_log.size(); d0 = done_cnt;
      pulse_start(32'd1, 16'd1);
      wait_idle("t5b", 8000);
      tick(20);
      check_run("t5b", q0, c0, 32'd1, 1);
      chk("t5b done_cnt", done_cnt - d0, 1);
      chk("t5b blocks_sent", blocks_sent, 16'd1);
`ifdef UART_PARITY_EN
      chk("parity", par_err, 0);
`endif

      // 6: asynchronous reset mid-frame
      pulse_start(32'd9, 16'd2);
      tick(250);
      n = 0;
      while (uart_tx !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      chk("t6 line_low", uart_tx, 1'b0);
      rst = 1'b1;
      #2;
      chk("t6 rst_uart_tx", uart_tx, 1'b1);
      chk("t6 rst_busy", busy, 1'b0);
      tick(3);
      rst = 1'b0;
      tick(2 * FCYC);
      q0 = rx_q.size(); c0 = ctr_log.size();
      tick(300);
      chk("t6 quiet_frames", rx_q.size() - q0, 0);
      chk("t6 quiet_req", ctr_log.size() - c0, 0);
      chk("t6 blocks_sent", blocks_sent, 16'd0);
      chk("t6 uart_idle", uart_tx, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
